// File: rtl/uart_echo_fifo.sv
// UART echo with a receive FIFO: frames arriving on uart_rx are checked, buffered
// and retransmitted on uart_tx with a configurable data width, parity and stop count.
module uart_echo_fifo #(
  parameter int clk_freq    = 25_000_000,
  parameter int baud_rate   = 115_200,
  parameter int data_bits   = 8,
  parameter int parity_mode = 0,
  parameter int stop_bits   = 1,
  parameter int fifo_depth  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          uart_rx,
  output logic                          uart_tx,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_overflow,
  output logic [$clog2(fifo_depth):0]   fifo_count
);

  localparam int CPB = clk_freq / baud_rate;
  localparam int CW  = $clog2(CPB);
  localparam int BW  = $clog2(data_bits + 1);
  localparam int AW  = $clog2(fifo_depth);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(CPB / 2);
  localparam logic [BW-1:0] DATA_LAST = BW'(data_bits - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(stop_bits - 1);
  localparam logic          PAR_ODD   = (parity_mode == 2);
  localparam bit            PAR_EN    = (parity_mode != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Reset asserts asynchronously but is released in step with clk.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  logic rx_meta_q, rx_sync_q, rx_prev_q;
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  logic [data_bits-1:0] mem [fifo_depth];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q, count_d;
  logic                 push, pop, full;

  state_t               rx_state_q;
  logic [CW-1:0]        rx_cnt_q;
  logic [BW-1:0]        rx_bit_q;
  logic [data_bits-1:0] rx_shift_q;
  logic                 rx_par_q, rx_frame_err_q, rx_parity_err_q, rx_overflow_q;
  logic                 rx_stop_evt, rx_par_ok;

  state_t               tx_state_q;
  logic [CW-1:0]        tx_cnt_q;
  logic [BW-1:0]        tx_bit_q;
  logic [data_bits-1:0] tx_shift_q;
  logic                 tx_par_q, tx_q, tx_last_stop;

  assign full         = (count_q == (AW+1)'(fifo_depth));
  assign rx_stop_evt  = (rx_state_q == S_STOP) && (rx_cnt_q == '0);
  assign rx_par_ok    = !PAR_EN || ((^rx_shift_q ^ rx_par_q) == PAR_ODD);
  assign push         = rx_stop_evt && rx_sync_q && rx_par_ok && (!full || pop);
  assign tx_last_stop = (tx_state_q == S_STOP) && (tx_cnt_q == '0) && (tx_bit_q == STOP_LAST);
  // Popping at the last stop cycle chains frames with no idle gap.
  assign pop          = ((tx_state_q == S_IDLE) || tx_last_stop) && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!push && pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= rx_shift_q;
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      rx_state_q      <= S_IDLE;
      rx_cnt_q        <= '0;
      rx_bit_q        <= '0;
      rx_shift_q      <= '0;
      rx_par_q        <= 1'b0;
      rx_frame_err_q  <= 1'b0;
      rx_parity_err_q <= 1'b0;
      rx_overflow_q   <= 1'b0;
    end else begin
      rx_frame_err_q  <= 1'b0;
      rx_parity_err_q <= 1'b0;
      rx_overflow_q   <= 1'b0;
      case (rx_state_q)
        S_IDLE: if (rx_prev_q && !rx_sync_q) begin
          rx_state_q <= S_START;
          rx_cnt_q   <= BAUD_HALF;
        end
        S_START: if (rx_cnt_q != '0) rx_cnt_q <= rx_cnt_q - CW'(1);
          else if (rx_sync_q) rx_state_q <= S_IDLE;
          else begin
            rx_state_q <= S_DATA;
            rx_cnt_q   <= BAUD_LAST;
            rx_bit_q   <= '0;
          end
        S_DATA: if (rx_cnt_q != '0) rx_cnt_q <= rx_cnt_q - CW'(1);
          else begin
            rx_shift_q <= {rx_sync_q, rx_shift_q[data_bits-1:1]};
            rx_cnt_q   <= BAUD_LAST;
            rx_bit_q   <= rx_bit_q + BW'(1);
            if (rx_bit_q == DATA_LAST) rx_state_q <= PAR_EN ? S_PARITY : S_STOP;
          end
        S_PARITY: if (rx_cnt_q != '0) rx_cnt_q <= rx_cnt_q - CW'(1);
          else begin
            rx_par_q   <= rx_sync_q;
            rx_cnt_q   <= BAUD_LAST;
            rx_state_q <= S_STOP;
          end
        S_STOP: if (rx_cnt_q != '0) rx_cnt_q <= rx_cnt_q - CW'(1);
          else begin
            rx_state_q <= S_IDLE;
            if (!rx_sync_q)       rx_frame_err_q  <= 1'b1;
            else if (!rx_par_ok)  rx_parity_err_q <= 1'b1;
            else if (full && !pop) rx_overflow_q  <= 1'b1;
          end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else if (pop) begin
      tx_state_q <= S_START;
      tx_cnt_q   <= BAUD_LAST;
      tx_shift_q <= mem[rd_ptr_q];
      tx_par_q   <= ^mem[rd_ptr_q] ^ PAR_ODD;
      tx_q       <= 1'b0;
    end else begin
      case (tx_state_q)
        S_IDLE: tx_q <= 1'b1;
        S_START: if (tx_cnt_q != '0) tx_cnt_q <= tx_cnt_q - CW'(1);
          else begin
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_bit_q   <= '0;
            tx_cnt_q   <= BAUD_LAST;
            tx_state_q <= S_DATA;
          end
        S_DATA: if (tx_cnt_q != '0) tx_cnt_q <= tx_cnt_q - CW'(1);
          else begin
            tx_cnt_q <= BAUD_LAST;
            if (tx_bit_q == DATA_LAST) begin
              tx_bit_q <= '0;
              if (PAR_EN) begin
                tx_q       <= tx_par_q;
                tx_state_q <= S_PARITY;
              end else begin
                tx_q       <= 1'b1;
                tx_state_q <= S_STOP;
              end
            end else begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
              tx_bit_q   <= tx_bit_q + BW'(1);
            end
          end
        S_PARITY: if (tx_cnt_q != '0) tx_cnt_q <= tx_cnt_q - CW'(1);
          else begin
            tx_q       <= 1'b1;
            tx_bit_q   <= '0;
            tx_cnt_q   <= BAUD_LAST;
            tx_state_q <= S_STOP;
          end
        S_STOP: if (tx_cnt_q != '0) tx_cnt_q <= tx_cnt_q - CW'(1);
          else if (tx_bit_q == STOP_LAST) tx_state_q <= S_IDLE;
          else begin
            tx_bit_q <= tx_bit_q + BW'(1);
            tx_cnt_q <= BAUD_LAST;
          end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  assign uart_tx       = tx_q;
  assign rx_frame_err  = rx_frame_err_q;
  assign rx_parity_err = rx_parity_err_q;
  assign rx_overflow   = rx_overflow_q;
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: three instances (8N1 depth 16, even parity, depth 4 with
// two TX stop bits) driven by serial frames and checked by a serial decoder on uart_tx.
`timescale 1ns/1ps
module tb_uart_echo_fifo;
  localparam int CPB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst_n_o;
  logic       rx_w [3];
  logic       tx_w [3];
  logic       ferr_w [3];
  logic       perr_w [3];
  logic       ovf_w [3];
  logic [4:0] cnt_a, cnt_p;
  logic [2:0] cnt_o;

  uart_echo_fifo #(.clk_freq(8), .baud_rate(1)) u_dut_a (
    .clk(clk), .reset_n(rst_n), .uart_rx(rx_w[0]), .uart_tx(tx_w[0]),
    .rx_frame_err(ferr_w[0]), .rx_parity_err(perr_w[0]), .rx_overflow(ovf_w[0]),
    .fifo_count(cnt_a));

  uart_echo_fifo #(.clk_freq(8), .baud_rate(1), .parity_mode(1)) u_dut_p (
    .clk(clk), .reset_n(rst_n), .uart_rx(rx_w[1]), .uart_tx(tx_w[1]),
    .rx_frame_err(ferr_w[1]), .rx_parity_err(perr_w[1]), .rx_overflow(ovf_w[1]),
    .fifo_count(cnt_p));

  uart_echo_fifo #(.clk_freq(8), .baud_rate(1), .stop_bits(2), .fifo_depth(4)) u_dut_o (
    .clk(clk), .reset_n(rst_n_o), .uart_rx(rx_w[2]), .uart_tx(tx_w[2]),
    .rx_frame_err(ferr_w[2]), .rx_parity_err(perr_w[2]), .rx_overflow(ovf_w[2]),
    .fifo_count(cnt_o));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nz[3]     = '{0, 0, 0};
  int txlow[3]  = '{0, 0, 0};
  int ferr_n[3] = '{0, 0, 0};
  int perr_n[3] = '{0, 0, 0};
  int ovf_n[3]  = '{0, 0, 0};
  int maxc_o    = 0;
  int last_start[3] = '{0, 0, 0};
  int prev_start[3] = '{0, 0, 0};
  bit mon_en[3]     = '{1'b1, 1'b1, 1'b1};

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic [7:0] got2[$];
  logic [7:0] sent2[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Event counters sampled between active edges.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (ferr_w[i] === 1'b1) ferr_n[i] <= ferr_n[i] + 1;
      if (perr_w[i] === 1'b1) perr_n[i] <= perr_n[i] + 1;
      if (ovf_w[i] === 1'b1)  ovf_n[i]  <= ovf_n[i] + 1;
      if (tx_w[i] === 1'b0)   txlow[i]  <= txlow[i] + 1;
    end
    if (cnt_a != 5'd0) nz[0] <= nz[0] + 1;
    if (cnt_p != 5'd0) nz[1] <= nz[1] + 1;
    if (cnt_o != 3'd0) nz[2] <= nz[2] + 1;
    if (int'(cnt_o) > maxc_o) maxc_o <= int'(cnt_o);
  end

  task automatic set_rx(input int sel, input logic v);
    rx_w[sel] = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put_bit(input int sel, input logic v);
    set_rx(sel, v);
    idle(CPB);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input bit par_en,
                            input logic pbit, input logic stopv);
    put_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) put_bit(sel, d[i]);
    if (par_en) put_bit(sel, pbit);
    put_bit(sel, stopv);
    set_rx(sel, 1'b1);
  endtask

  function automatic int pending(input int sel);
    return (sel == 0) ? exp0.size() : exp1.size();
  endfunction

  task automatic wait_empty(input int sel, input int budget);
    int n = 0;
    while (pending(sel) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check($sformatf("drain%0d", sel), pending(sel), 0);
  endtask

  // Serial decoder: samples each uart_tx bit at its centre and checks it against the queue.
  task automatic monitor(input int sel, input bit par_en, input int nstop);
    logic [7:0] w;
    logic       sb, pb, stop_ok;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (tx_w[sel] === 1'b0) begin
        prev_start[sel] = last_start[sel];
        last_start[sel] = cyc;
        repeat (4) @(negedge clk);
        sb = tx_w[sel];
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          w[i] = tx_w[sel];
        end
        pb = 1'b0;
        if (par_en) begin
          repeat (CPB) @(negedge clk);
          pb = tx_w[sel];
        end
        stop_ok = 1'b1;
        for (int s = 0; s < nstop; s++) begin
          repeat (CPB) @(negedge clk);
          if (tx_w[sel] !== 1'b1) stop_ok = 1'b0;
        end
        if (mon_en[sel]) begin
          check($sformatf("tx%0d_start", sel), sb, 0);
          check($sformatf("tx%0d_stop", sel), stop_ok, 1);
          if (par_en) check($sformatf("tx%0d_parity", sel), pb, ^w);
          if (sel == 2) got2.push_back(w);
          else begin
            check($sformatf("tx%0d_pending", sel), pending(sel) != 0, 1);
            if (pending(sel) != 0) begin
              e = (sel == 0) ? exp0.pop_front() : exp1.pop_front();
              check($sformatf("tx%0d_word", sel), w, e);
            end
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int         f0, p0, o0, t0, n0, nbad, j;
  bit         ok, bad;
  logic [7:0] d;

  initial begin
    rst_n = 1'b0;
    rst_n_o = 1'b0;
    for (int i = 0; i < 3; i++) rx_w[i] = 1'b1;
    fork
      monitor(0, 1'b0, 1);
      monitor(1, 1'b1, 1);
      monitor(2, 1'b0, 2);
    join_none
    idle(3);
    rst_n = 1'b1;
    rst_n_o = 1'b1;
    idle(6);

    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_tx%0d", i), tx_w[i], 1);
      check($sformatf("rst_err%0d", i), {ferr_w[i], perr_w[i], ovf_w[i]}, 0);
    end
    check("rst_cnt", {cnt_a, cnt_p, cnt_o}, 0);

    // Single 8N1 word: buffered for one cycle, echoed, no errors.
    f0 = ferr_n[0]; n0 = nz[0];
    exp0.push_back(8'hAA);
    send_frame(0, 8'hAA, 1'b0, 1'b0, 1'b1);
    wait_empty(0, 300);
    idle(10);
    check("t1_count_cycles", nz[0] - n0, 1);
    check("t1_ferr", ferr_n[0] - f0, 0);

    // Back-to-back frames: second start bit follows the first stop bit directly.
    exp0.push_back(8'hAA);
    exp0.push_back(8'h9D);
    send_frame(0, 8'hAA, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h9D, 1'b0, 1'b0, 1'b1);
    wait_empty(0, 400);
    check("t2_start_spacing", last_start[0] - prev_start[0], 10 * CPB);

    // Short low glitch is ignored.
    t0 = txlow[0]; n0 = nz[0]; f0 = ferr_n[0];
    set_rx(0, 1'b0);
    idle(2);
    set_rx(0, 1'b1);
    idle(120);
    check("t3_tx_quiet", txlow[0] - t0, 0);
    check("t3_no_push", nz[0] - n0, 0);
    check("t3_no_err", ferr_n[0] - f0, 0);

    // Bad stop bit: one frame error, no echo.
    t0 = txlow[0]; n0 = nz[0]; f0 = ferr_n[0];
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    idle(120);
    check("t4_ferr", ferr_n[0] - f0, 1);
    check("t4_no_push", nz[0] - n0, 0);
    check("t4_tx_quiet", txlow[0] - t0, 0);

    // Random 8N1 stream with occasional framing errors.
    f0 = ferr_n[0]; o0 = ovf_n[0]; p0 = perr_n[0]; nbad = 0;
    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      if (bad) nbad++;
      else exp0.push_back(d);
      send_frame(0, d, 1'b0, 1'b0, !bad);
      idle(bad ? CPB : $urandom_range(0, 12));
    end
    wait_empty(0, 3000);
    idle(20);
    check("rnd_ferr", ferr_n[0] - f0, nbad);
    check("rnd_ovf", ovf_n[0] - o0, 0);
    check("rnd_perr", perr_n[0] - p0, 0);

    // Even parity: wrong parity dropped, correct parity echoed.
    p0 = perr_n[1]; t0 = txlow[1];
    send_frame(1, 8'h9D, 1'b1, 1'b0, 1'b1);
    idle(120);
    check("t5_perr", perr_n[1] - p0, 1);
    check("t5_no_echo", txlow[1] - t0, 0);
    exp1.push_back(8'h9D);
    send_frame(1, 8'h9D, 1'b1, 1'b1, 1'b1);
    wait_empty(1, 300);

    p0 = perr_n[1]; f0 = ferr_n[1]; nbad = 0;
    for (int k = 0; k < 16; k++) begin
      d = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      if (bad) nbad++;
      else exp1.push_back(d);
      send_frame(1, d, 1'b1, (^d) ^ bad, 1'b1);
      idle($urandom_range(0, 10));
    end
    wait_empty(1, 3000);
    idle(20);
    check("rnd_perr_count", perr_n[1] - p0, nbad);
    check("rnd_perr_ferr", ferr_n[1] - f0, 0);

    // Continuous stream into a slower transmitter: FIFO fills, excess words dropped.
    o0 = ovf_n[2];
    for (int k = 0; k < 70; k++) begin
      d = 8'($urandom);
      sent2.push_back(d);
      send_frame(2, d, 1'b0, 1'b0, 1'b1);
    end
    for (int k = 0; k < 3000 && cnt_o != 3'd0; k++) @(posedge clk);
    idle(150);
    check("t6_drained", cnt_o, 0);
    check("t6_max_count", maxc_o, 4);
    check("t6_ovf_seen", (ovf_n[2] - o0) > 0, 1);
    check("t6_conserve", got2.size() + ovf_n[2] - o0, 70);
    j = 0; ok = 1'b1;
    foreach (got2[k]) begin
      while (j < sent2.size() && sent2[j] != got2[k]) j++;
      if (j >= sent2.size()) ok = 1'b0;
      else j++;
    end
    check("t6_in_order", ok, 1);

    // Reset mid-transmission of zero words with one word still buffered.
    mon_en[2] = 1'b0;
    for (int k = 0; k < 4; k++) send_frame(2, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(3);
    rst_n_o = 1'b0;
    #1;
    check("t6_rst_tx", tx_w[2], 1);
    check("t6_rst_cnt", cnt_o, 0);
    idle(3);
    rst_n_o = 1'b1;
    idle(12);
    check("t6_post_tx", tx_w[2], 1);
    check("t6_post_cnt", cnt_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
